// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage core: freezes on D-miss, inserts load-use/jr bubbles,
// flushes on taken control transfers, parks on halt, and counts stall cycles for perf reporting.
module hazard_sequencer #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_me,
  input  logic             dWEN_me,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             useRt_de,
  input  logic             jr_de,
  input  logic             memRd_ex,
  input  logic [4:0]       regDst_ex,
  input  logic [4:0]       regDst_me,
  input  logic             pcSrc_ex,
  input  logic             halt_wb,
  output logic             pcEn,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {RUN, DWAIT, LDSTALL, HALT} state_t;

  state_t     state, nextState;
  logic [1:0] cnt, nextCnt;
  logic [3:0] en;     // {fd, de, em, mw}
  logic [2:0] flush;  // {fd, de, em}
  logic       dmiss, ldUse, jrLd;

  localparam logic [3:0] EN_ALL    = 4'b1111;
  localparam logic [3:0] EN_NONE   = 4'b0000;
  localparam logic [3:0] EN_BUBBLE = 4'b0111;

  assign dmiss = (dREN_me | dWEN_me) & ~dhit;
  assign ldUse = memRd_ex & (regDst_ex != 5'd0) &
                 ((rs_de == regDst_ex) | (useRt_de & (rt_de == regDst_ex)));
  assign jrLd  = jr_de & dREN_me & (regDst_me != 5'd0) & (rs_de == regDst_me);

  // The detecting cycle is the first bubble; LDSTALL only covers bubbles beyond it.
  always_comb begin
    pcEn      = 1'b1;
    en        = EN_ALL;
    flush     = 3'b000;
    halted    = 1'b0;
    nextState = state;
    nextCnt   = cnt;
    if (RST) begin
      pcEn      = 1'b0;
      en        = EN_NONE;
      flush     = 3'b111;
      nextState = RUN;
      nextCnt   = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_wb) begin
            pcEn      = 1'b0;
            en        = EN_NONE;
            nextState = HALT;
          end else if (dmiss) begin
            pcEn      = 1'b0;
            en        = EN_NONE;
            nextState = DWAIT;
          end else if (ldUse | jrLd) begin
            pcEn  = 1'b0;
            en    = EN_BUBBLE;
            flush = {pcSrc_ex, 2'b10};
            if (LU_BUBBLES > 1) begin
              nextState = LDSTALL;
              nextCnt   = 2'(LU_BUBBLES - 1);
            end
          end else if (pcSrc_ex) begin
            flush = 3'b110;
          end else if (!ihit) begin
            pcEn  = 1'b0;
            en    = EN_BUBBLE;
            flush = 3'b010;
          end
        end
        DWAIT: begin
          if (halt_wb) begin
            pcEn      = 1'b0;
            en        = EN_NONE;
            nextState = HALT;
          end else if (!dhit) begin
            pcEn = 1'b0;
            en   = EN_NONE;
          end else begin
            nextState = RUN;
          end
        end
        LDSTALL: begin
          if (halt_wb) begin
            pcEn      = 1'b0;
            en        = EN_NONE;
            nextState = HALT;
          end else if (dmiss) begin
            pcEn      = 1'b0;
            en        = EN_NONE;
            nextState = DWAIT;
            nextCnt   = 2'd0;
          end else begin
            pcEn  = 1'b0;
            en    = EN_BUBBLE;
            flush = 3'b010;
            if (cnt <= 2'd1) begin
              nextState = RUN;
              nextCnt   = 2'd0;
            end else begin
              nextCnt = cnt - 2'd1;
            end
          end
        end
        HALT: begin
          pcEn   = 1'b0;
          en     = EN_NONE;
          halted = 1'b1;
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state <= nextState;
    cnt   <= nextCnt;
    if (RST)
      stallCnt <= '0;
    else if (!pcEn && state != HALT && stallCnt != {CNT_W{1'b1}})
      stallCnt <= stallCnt + 1'b1;
  end

  assign {en_fd, en_de, en_em, en_mw} = en;
  assign {flush_fd, flush_de, flush_em} = flush;
  assign dbgState = state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: per-cycle expected output vectors are queued as
// stimulus is driven and popped when outputs are sampled on the falling edge.
module tb_hazard_sequencer;

  localparam int CW = 4;

  typedef struct packed {
    logic       ihit, dhit, dREN, dWEN;
    logic [4:0] rs, rt;
    logic       useRt, jr, memRd;
    logic [4:0] rdEx, rdMe;
    logic       pcSrc, halt;
  } stim_t;

  // {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted}
  localparam logic [8:0] RUN_OK  = 9'b1_1111_000_0;
  localparam logic [8:0] FREEZE  = 9'b0_0000_000_0;
  localparam logic [8:0] STALL   = 9'b0_0111_010_0;
  localparam logic [8:0] STALLBR = 9'b0_0111_110_0;
  localparam logic [8:0] BRANCH  = 9'b1_1111_110_0;
  localparam logic [8:0] RESETV  = 9'b0_0000_111_0;
  localparam logic [8:0] HALTV   = 9'b0_0000_000_1;

  logic CLK, RST, ihit, dhit, dREN_me, dWEN_me, useRt_de, jr_de, memRd_ex, pcSrc_ex, halt_wb;
  logic [4:0] rs_de, rt_de, regDst_ex, regDst_me;
  logic pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted;
  logic [CW-1:0] stallCnt;
  logic [1:0] dbgState;

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] expCnt;

  hazard_sequencer #(.LU_BUBBLES(1), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_me(dREN_me), .dWEN_me(dWEN_me),
    .rs_de(rs_de), .rt_de(rt_de), .useRt_de(useRt_de), .jr_de(jr_de), .memRd_ex(memRd_ex),
    .regDst_ex(regDst_ex), .regDst_me(regDst_me), .pcSrc_ex(pcSrc_ex), .halt_wb(halt_wb),
    .pcEn(pcEn), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .halted(halted),
    .stallCnt(stallCnt), .dbgState(dbgState)
  );

  // clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic logic [8:0] outs();
    return {pcEn, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halted};
  endfunction

  // driver
  task automatic apply(input stim_t s);
    ihit = s.ihit; dhit = s.dhit; dREN_me = s.dREN; dWEN_me = s.dWEN;
    rs_de = s.rs; rt_de = s.rt; useRt_de = s.useRt; jr_de = s.jr; memRd_ex = s.memRd;
    regDst_ex = s.rdEx; regDst_me = s.rdMe; pcSrc_ex = s.pcSrc; halt_wb = s.halt;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    RST = 1'b1;
    apply(idle());
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(RESETV);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL reset_out[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    checks++;
    if (stallCnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", stallCnt);
    end
    RST = 1'b0;
    exp_q.push_back(RUN_OK);
    @(negedge CLK);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL reset_first_run: got %b expected %b", outs(), e);
    end
    step();
    expCnt = '0;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [8:0] ex[$];
    stim_t s;
    logic [8:0] e;
    s = idle(); s.memRd = 1; s.rdEx = 8; s.rs = 8;                st.push_back(s); ex.push_back(STALL);
    s = idle();                                                   st.push_back(s); ex.push_back(RUN_OK);
    s = idle(); s.memRd = 1; s.rdEx = 5; s.rs = 3; s.rt = 5; s.useRt = 1; st.push_back(s); ex.push_back(STALL);
    s = idle(); s.memRd = 1; s.rdEx = 5; s.rs = 3; s.rt = 5;      st.push_back(s); ex.push_back(RUN_OK);
    s = idle(); s.memRd = 1; s.rdEx = 0; s.rs = 0;                st.push_back(s); ex.push_back(RUN_OK);
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
      if (i == 1) begin
        checks++;
        if (stallCnt !== 4'd1) begin
          errors++;
          $display("FAIL load_use_cnt: got %0d expected 1", stallCnt);
        end
      end
    end
    expCnt = 4'd2;
  endtask

  task automatic test_dmiss();
    logic [8:0] e;
    stim_t s;
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.dREN = 1; s.dhit = (i == 4);
      apply(s);
      exp_q.push_back(i == 4 ? RUN_OK : FREEZE);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL dmiss[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    expCnt = expCnt + 4'd4;
    checks++;
    if (stallCnt !== expCnt) begin
      errors++;
      $display("FAIL dmiss_cnt: got %0d expected %0d", stallCnt, expCnt);
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    logic [8:0] ex[$];
    stim_t s;
    logic [8:0] e;
    s = idle(); s.pcSrc = 1;                                 st.push_back(s); ex.push_back(BRANCH);
    s = idle(); s.pcSrc = 1; s.memRd = 1; s.rdEx = 9; s.rs = 9; st.push_back(s); ex.push_back(STALLBR);
    s = idle();                                              st.push_back(s); ex.push_back(RUN_OK);
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL branch[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    expCnt = expCnt + 4'd1;
    checks++;
    if (stallCnt !== expCnt) begin
      errors++;
      $display("FAIL branch_cnt: got %0d expected %0d", stallCnt, expCnt);
    end
  endtask

  task automatic test_jr_ihit_priority();
    stim_t st[$];
    logic [8:0] ex[$];
    stim_t s;
    logic [8:0] e;
    s = idle(); s.jr = 1; s.rs = 31; s.dREN = 1; s.rdMe = 31; s.dhit = 1; st.push_back(s); ex.push_back(STALL);
    s = idle();                                                         st.push_back(s); ex.push_back(RUN_OK);
    s = idle(); s.jr = 1; s.rs = 0; s.dREN = 1; s.rdMe = 0; s.dhit = 1;   st.push_back(s); ex.push_back(RUN_OK);
    s = idle(); s.ihit = 0;                                              st.push_back(s); ex.push_back(STALL);
    s = idle(); s.dWEN = 1; s.pcSrc = 1; s.memRd = 1; s.rdEx = 4; s.rs = 4; st.push_back(s); ex.push_back(FREEZE);
    s = idle(); s.dWEN = 1; s.dhit = 1;                                  st.push_back(s); ex.push_back(RUN_OK);
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL jr_ihit_prio[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    expCnt = expCnt + 4'd3;
    checks++;
    if (stallCnt !== expCnt) begin
      errors++;
      $display("FAIL jr_ihit_prio_cnt: got %0d expected %0d", stallCnt, expCnt);
    end
  endtask

  task automatic test_reset_mid_dwait();
    stim_t s;
    logic [8:0] e;
    s = idle(); s.dREN = 1;
    apply(s);
    step();
    RST = 1'b1;
    exp_q.push_back(RESETV);
    @(negedge CLK);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL rst_mid_out: got %b expected %b", outs(), e);
    end
    step();
    RST = 1'b0;
    apply(idle());
    exp_q.push_back(RUN_OK);
    @(negedge CLK);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL rst_mid_run: got %b expected %b", outs(), e);
    end
    step();
    expCnt = '0;
    checks++;
    if (stallCnt !== expCnt) begin
      errors++;
      $display("FAIL rst_mid_cnt: got %0d expected 0", stallCnt);
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    logic [8:0] e;
    s = idle(); s.dREN = 1;
    apply(s);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(FREEZE);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL sat_freeze[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    checks++;
    if (stallCnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt: got %0d expected 15", stallCnt);
    end
    s.dhit = 1;
    apply(s);
    step();
  endtask

  task automatic test_halt();
    stim_t s;
    logic [8:0] e;
    RST = 1'b1;
    apply(idle());
    step();
    RST = 1'b0;
    s = idle(); s.ihit = 0;
    apply(s);
    step();
    s = idle(); s.halt = 1;
    apply(s);
    step();
    s = idle(); s.ihit = 0; s.dREN = 1;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(HALTV);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL halt_out[%0d]: got %b expected %b", i, outs(), e);
      end
      step();
    end
    checks++;
    if (stallCnt !== 4'd2) begin
      errors++;
      $display("FAIL halt_cnt: got %0d expected 2", stallCnt);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    apply(idle());
    exp_q.push_back(RUN_OK);
    @(negedge CLK);
    e = exp_q.pop_front();
    checks++;
    if (outs() !== e) begin
      errors++;
      $display("FAIL halt_cleared: got %b expected %b", outs(), e);
    end
    step();
  endtask

  initial begin
    RST = 1'b1;
    apply(idle());
    test_reset();
    test_load_use();
    test_dmiss();
    test_branch();
    test_jr_ihit_priority();
    test_reset_mid_dwait();
    test_saturation();
    test_halt();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
